// File: rtl/systola_pkg.sv
// systola_pkg: shared state encoding, width helper and parameter checks for the systolic array
package systola_pkg;
  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic bit cfg_ok(input int rows, input int cols, input int dw, input int aw);
    return rows >= 1 && cols >= 1 && aw >= 2 * dw;
  endfunction
endpackage

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: output-stationary MAC cell forwarding a right and w down
module systolic_mac_pe #(
  parameter int DW = 8,
  parameter int AW = 32,
  parameter bit SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] w_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] w_out,
  output logic [AW-1:0] acc
);
  logic signed [2*DW-1:0] ps;
  logic [2*DW-1:0] pu;
  logic [AW-1:0] ext;
  assign ps = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{w_in[DW-1]}}, w_in});
  assign pu = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, w_in};
  assign ext = SIGNED ? AW'(ps) : AW'(pu);
  always_ff @(posedge clk)
    if (rst || clr) begin
      a_out <= '0;
      w_out <= '0;
      acc <= '0;
    end else if (en) begin
      a_out <= a_in;
      w_out <= w_in;
      acc <= acc + ext;
    end
endmodule

// File: rtl/systolic_os_array.sv
// systolic_os_array: output-stationary ROWSxCOLS matrix-multiply array with skew, flush and row drain
module systolic_os_array
  import systola_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW = 8,
  parameter int AW = 32,
  parameter bit SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [ROWS*DW-1:0]       in_a,
  input  logic [COLS*DW-1:0]       in_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*AW-1:0]       out_row,
  output logic [idx_w(ROWS)-1:0]   out_idx,
  output logic                     busy
);
  localparam int IW = idx_w(ROWS);
  localparam int FL = ROWS + COLS - 2;
  localparam int FW = idx_w(FL + 1);
  if (!cfg_ok(ROWS, COLS, DW, AW)) begin : g_bad
    $error("systolic_os_array: need ROWS,COLS >= 1 and AW >= 2*DW");
  end
  state_t st, nst;
  logic [FW-1:0] fcnt;
  logic adv, clr, last_row;
  logic [DW-1:0] a_edge [ROWS];
  logic [DW-1:0] w_edge [COLS];
  logic [DW-1:0] ah [ROWS][COLS+1];
  logic [DW-1:0] wv [ROWS+1][COLS];
  logic [AW-1:0] acc [ROWS][COLS];
  logic [ROWS-1:0] unused_a;
  logic [COLS-1:0] unused_w;
  assign busy = st != IDLE;
  assign last_row = out_idx == IW'(ROWS - 1);
  assign clr = out_valid && out_ready && last_row;
  always_comb begin
    nst = st;
    in_ready = !rst && (st == IDLE || st == COMPUTE);
    out_valid = st == DRAIN;
    adv = st == FLUSH || (in_valid && in_ready);
    unique case (st)
      IDLE, COMPUTE: if (adv) nst = !in_last ? COMPUTE : (FL == 0 ? DRAIN : FLUSH);
      FLUSH:         if (fcnt == FW'(FL - 1)) nst = DRAIN;
      DRAIN:         if (out_ready && last_row) nst = IDLE;
      default:       nst = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      fcnt <= '0;
      out_idx <= '0;
    end else begin
      st <= nst;
      fcnt <= st == FLUSH ? fcnt + 1'b1 : '0;
      if (out_valid && out_ready) out_idx <= last_row ? '0 : out_idx + 1'b1;
    end
  // row r of A is delayed r beats so every wavefront meets its W column in lockstep
  for (genvar r = 0; r < ROWS; r++) begin : g_sa
    logic [DW-1:0] src;
    assign src = st == FLUSH ? '0 : in_a[r*DW +: DW];
    if (r == 0) begin : g_n
      assign a_edge[r] = src;
    end else begin : g_d
      logic [DW-1:0] sk [r];
      always_ff @(posedge clk)
        if (rst) sk <= '{default: '0};
        else if (adv) begin
          sk[0] <= src;
          for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
        end
      assign a_edge[r] = sk[r-1];
    end
    assign ah[r][0] = a_edge[r];
    assign unused_a[r] = ^ah[r][COLS];
  end
  for (genvar c = 0; c < COLS; c++) begin : g_sw
    logic [DW-1:0] src;
    assign src = st == FLUSH ? '0 : in_w[c*DW +: DW];
    if (c == 0) begin : g_n
      assign w_edge[c] = src;
    end else begin : g_d
      logic [DW-1:0] sk [c];
      always_ff @(posedge clk)
        if (rst) sk <= '{default: '0};
        else if (adv) begin
          sk[0] <= src;
          for (int i = 1; i < c; i++) sk[i] <= sk[i-1];
        end
      assign w_edge[c] = sk[c-1];
    end
    assign wv[0][c] = w_edge[c];
    assign unused_w[c] = ^wv[ROWS][c];
    assign out_row[c*AW +: AW] = acc[out_idx][c];
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      systolic_mac_pe #(.DW(DW), .AW(AW), .SIGNED(SIGNED)) u_pe (
        .clk(clk), .rst(rst), .en(adv), .clr(clr),
        .a_in(ah[r][c]), .w_in(wv[r][c]),
        .a_out(ah[r][c+1]), .w_out(wv[r+1][c]),
        .acc(acc[r][c])
      );
    end
  end
endmodule

// File: tb/tb_systolic_os_array.sv
// tb_systolic_os_array: scoreboard bench over three array configurations sharing one stimulus bus
module tb_systolic_os_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v = 1'b0, last = 1'b0, ordy = 1'b0;
  logic [31:0] a_bus = '0, w_bus = '0;
  int sel = 0;
  int cyc = 0;
  int total = 0, bad = 0;
  int t_acc = 0;
  logic v0, v1, v2, or0, or1, or2;
  logic rdy0, rdy1, rdy2, ov0, ov1, ov2, busy0, busy1, busy2;
  logic [63:0] row0;
  logic [127:0] row1;
  logic [31:0] row2;
  logic [0:0] idx0, idx2;
  logic [1:0] idx1;
  logic rdy_m, ov_m, busy_m;
  logic [127:0] row_m;
  int idx_m;
  typedef struct { int idx; logic [127:0] row; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v0 = v && sel == 0;
  assign v1 = v && sel == 1;
  assign v2 = v && sel == 2;
  assign or0 = ordy && sel == 0;
  assign or1 = ordy && sel == 1;
  assign or2 = ordy && sel == 2;
  always_comb begin
    rdy_m = sel == 0 ? rdy0 : sel == 1 ? rdy1 : rdy2;
    ov_m = sel == 0 ? ov0 : sel == 1 ? ov1 : ov2;
    busy_m = sel == 0 ? busy0 : sel == 1 ? busy1 : busy2;
    row_m = sel == 0 ? {64'b0, row0} : sel == 1 ? row1 : {96'b0, row2};
    idx_m = sel == 0 ? {31'b0, idx0} : sel == 1 ? {30'b0, idx1} : {31'b0, idx2};
  end

  systolic_os_array #(.ROWS(2), .COLS(2), .DW(8), .AW(32), .SIGNED(0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_last(last),
    .in_a(a_bus[15:0]), .in_w(w_bus[15:0]), .out_valid(ov0), .out_ready(or0),
    .out_row(row0), .out_idx(idx0), .busy(busy0));
  systolic_os_array #(.ROWS(4), .COLS(4), .DW(8), .AW(32), .SIGNED(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_last(last),
    .in_a(a_bus), .in_w(w_bus), .out_valid(ov1), .out_ready(or1),
    .out_row(row1), .out_idx(idx1), .busy(busy1));
  systolic_os_array #(.ROWS(2), .COLS(2), .DW(8), .AW(16), .SIGNED(0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_last(last),
    .in_a(a_bus[15:0]), .in_w(w_bus[15:0]), .out_valid(ov2), .out_ready(or2),
    .out_row(row2), .out_idx(idx2), .busy(busy2));

  function automatic int nr(input int s); return s == 1 ? 4 : 2; endfunction
  function automatic int nc(input int s); return s == 1 ? 4 : 2; endfunction
  function automatic int aww(input int s); return s == 2 ? 16 : 32; endfunction
  function automatic bit sg(input int s); return s == 1; endfunction

  task automatic push_expected(input int nk, input logic [127:0] as, input logic [127:0] ws);
    exp_t e;
    logic [127:0] m, x;
    longint s, ea, ew;
    m = (128'd1 << aww(sel)) - 128'd1;
    for (int r = 0; r < nr(sel); r++) begin
      e.idx = r;
      e.row = '0;
      for (int c = 0; c < nc(sel); c++) begin
        s = 0;
        for (int k = 0; k < nk; k++) begin
          ea = sg(sel) ? longint'($signed(as[k*32 + r*8 +: 8])) : longint'(as[k*32 + r*8 +: 8]);
          ew = sg(sel) ? longint'($signed(ws[k*32 + c*8 +: 8])) : longint'(ws[k*32 + c*8 +: 8]);
          s += ea * ew;
        end
        x = 128'(s) & m;
        e.row |= x << (c * aww(sel));
      end
      q.push_back(e);
    end
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] w, input bit l);
    v = 1'b1;
    a_bus = a;
    w_bus = w;
    last = l;
    #1;
    for (int n = 0; n < 10 && !rdy_m; n++) @(negedge clk);
    total++;
    if (!rdy_m) begin
      bad++;
      $display("FAIL beat_accept sel=%0d in_ready=%b required=1", sel, rdy_m);
    end
    t_acc = cyc;
    @(negedge clk);
    v = 1'b0;
    last = 1'b0;
  endtask

  task automatic job(input int nk, input logic [127:0] as, input logic [127:0] ws, input int gap, input int stall);
    int lat;
    push_expected(nk, as, ws);
    for (int k = 0; k < nk; k++) begin
      beat(as[k*32 +: 32], ws[k*32 +: 32], k == nk - 1);
      if (k < nk - 1) repeat (gap) @(negedge clk);
    end
    lat = nr(sel) + nc(sel) - 1;
    for (int n = 0; n < 30 && !ov_m; n++) @(negedge clk);
    total++;
    if (!ov_m || cyc - t_acc != lat) begin
      bad++;
      $display("FAIL latency sel=%0d out_valid=%b got=%0d required=%0d", sel, ov_m, cyc - t_acc, lat);
    end
    for (int s = 0; s < stall; s++) begin
      total++;
      if (!ov_m || idx_m != 0 || row_m !== q[0].row || rdy_m) begin
        bad++;
        $display("FAIL stall_hold sel=%0d valid=%b idx=%0d ready=%b row=%h required_row=%h",
                 sel, ov_m, idx_m, rdy_m, row_m, q[0].row);
      end
      @(negedge clk);
    end
    ordy = 1'b1;
    for (int n = 0; n < nr(sel); n++) begin
      total++;
      if (!ov_m || idx_m != q[0].idx || row_m !== q[0].row) begin
        bad++;
        $display("FAIL drain_row sel=%0d valid=%b idx=%0d required_idx=%0d row=%h required_row=%h",
                 sel, ov_m, idx_m, q[0].idx, row_m, q[0].row);
      end
      void'(q.pop_front());
      @(negedge clk);
    end
    ordy = 1'b0;
    total++;
    if (busy_m || !rdy_m) begin
      bad++;
      $display("FAIL end_idle sel=%0d busy=%b ready=%b required busy=0 ready=1", sel, busy_m, rdy_m);
    end
  endtask

  localparam logic [127:0] BA = {64'b0, 32'h0000_0402, 32'h0000_0301};
  localparam logic [127:0] BW = {64'b0, 32'h0000_0807, 32'h0000_0605};

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total++;
      if (busy_m || ov_m || idx_m != 0 || row_m !== '0 || rdy_m) begin
        bad++;
        $display("FAIL reset_state sel=%0d busy=%b valid=%b idx=%0d ready=%b row=%h required all 0",
                 sel, busy_m, ov_m, idx_m, rdy_m, row_m);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total++;
      if (!rdy_m || busy_m) begin
        bad++;
        $display("FAIL post_reset sel=%0d ready=%b busy=%b required ready=1 busy=0", sel, rdy_m, busy_m);
      end
    end
    sel = 0;
  endtask

  task automatic test_basic;
    sel = 0;
    job(2, BA, BW, 0, 0);
  endtask

  task automatic test_input_stall;
    sel = 0;
    job(2, BA, BW, 3, 0);
  endtask

  task automatic test_drain_backpressure;
    sel = 0;
    job(2, BA, BW, 0, 5);
  endtask

  task automatic test_back_to_back;
    sel = 0;
    job(3, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    job(2, BA, BW, 0, 0);
  endtask

  task automatic test_signed;
    sel = 1;
    job(1, {96'b0, 32'h8080_8080}, {96'b0, 32'h7f7f_7f7f}, 0, 0);
    job(4, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, 2);
  endtask

  task automatic test_wrap;
    sel = 2;
    job(2, {64'b0, 32'h0000_ffff, 32'h0000_ffff}, {64'b0, 32'h0000_ffff, 32'h0000_ffff}, 0, 0);
  endtask

  task automatic test_reset_mid_flush;
    sel = 0;
    beat(32'h0000_0907, 32'h0000_0b0d, 1'b0);
    beat(32'h0000_0f11, 32'h0000_1315, 1'b1);
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      total++;
      if (ov_m || busy_m || rdy_m) begin
        bad++;
        $display("FAIL reset_mid_flush valid=%b busy=%b ready=%b required all 0", ov_m, busy_m, rdy_m);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    job(2, BA, BW, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_input_stall;
    test_drain_backpressure;
    test_back_to_back;
    test_signed;
    test_wrap;
    test_reset_mid_flush;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/systolic_os_array.md
# systolic_os_array

Parametrised output-stationary systolic matrix-multiply array, successor to the fixed 8-bit PE grid. It computes C = A·W for an A of ROWS×K and a W of K×COLS, with K streamed at runtime. Operand skew, signed/unsigned mode, stall-tolerant valid/ready input, automatic wavefront flush and row-serial result drain are all built in. It sits between the operand fetch buffers and the result writeback.

## Interface
- ROWS, 4, array rows; one A row per PE row, ≥1
- COLS, 4, array columns; one W column per PE column, ≥1
- DW, 8, operand width
- AW, 32, accumulator/result width; must be ≥ 2·DW
- SIGNED, 0, 1 = two's-complement operands and results, 0 = unsigned
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  array accepts a beat
- in_last  in  1  beat is the final k of the job
- in_a  in  ROWS·DW  column k of A; element r in bits [r·DW +: DW]
- in_w  in  COLS·DW  row k of W; element c in bits [c·DW +: DW]
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts the row
- out_row  out  COLS·AW  C[out_idx][c] in bits [c·AW +: AW]
- out_idx  out  clog2(max(ROWS,2))  row index of out_row
- busy  out  1  job in progress (not IDLE)

## Operation
- The FSM has four states:
  - IDLE: accepted beat with in_last goes to FLUSH; without in_last goes to COMPUTE.
  - COMPUTE: accepted beat with in_last goes to FLUSH.
  - FLUSH: counts ROWS+COLS−2 cycles, then goes to DRAIN. When ROWS+COLS−2 = 0, FLUSH is skipped and the FSM goes straight to DRAIN.
  - DRAIN: goes to IDLE when row ROWS−1 is accepted.
- in_ready = 1 in IDLE and COMPUTE and 0 otherwise. It is forced to 0 while rst is high.
- Advance enable `adv` is (in_valid & in_ready) in IDLE/COMPUTE, 1 in FLUSH, and 0 in DRAIN. Skew registers, PE operand registers and accumulators change only when adv = 1. A cycle with in_valid = 0 is a full-array stall with no state change.
- Skew: element r of in_a passes through r registers before PE(r,0). Element c of in_w passes through c registers before PE(0,c). FLUSH injects zeros into both skew inputs.
- Each PE does acc += ext(a_in)·ext(w_in) on adv. It then forwards a right and w down through registers.
- Arithmetic:
  - Product is 2·DW bits, sign- or zero-extended to AW per SIGNED.
  - Accumulation wraps modulo 2^AW.
  - No saturation, no overflow flag.
- DRAIN:
  - out_valid = 1; out_row muxes the accumulators of row out_idx.
  - On out_valid & out_ready, out_idx increments.
  - On acceptance of row ROWS−1, all accumulators clear to 0 and out_idx returns to 0.
- in_last with in_valid = 0 is ignored.

## Timing
- Reset values:
  - FSM = IDLE, busy = 0, out_valid = 0, out_idx = 0.
  - out_row = 0, since all accumulators are 0.
  - All skew and PE registers are 0.
- Reset mid-job at any state aborts the job completely. No partial state survives.
- Beat k reaches PE(r,c) on the (r+c)-th advance after its acceptance.
- Latency: last beat accepted in cycle t gives out_valid = 1 in cycle t+ROWS+COLS−1 (1×1: t+1). FLUSH does not stall.
- Drain: ROWS rows, one per cycle when out_ready = 1. While out_ready = 0, out_row and out_idx hold stable.
- Back-to-back jobs: in_ready rises the cycle after the final row is accepted. A beat accepted in that cycle starts from cleared accumulators.

## Structure
- Shared package systola_pkg holds:
  - state enum {IDLE, COMPUTE, FLUSH, DRAIN};
  - a clog2-based width function;
  - elaboration checks for AW ≥ 2·DW and ROWS, COLS ≥ 1.
- Sub-module systolic_mac_pe is one PE with ports en, clr, a_in/w_in, a_out/w_out and acc. The top instantiates it ROWS×COLS times and owns the skew lines, FSM, flush counter and drain mux.

## Test plan
- ROWS=COLS=2, DW=8, unsigned, A=[[1,2],[3,4]], W=[[5,6],[7,8]]:
  - Stimulus: beats a=(1,3),w=(5,6) then a=(2,4),w=(7,8),last.
  - Response: row0 = (19,22), row1 = (43,50); out_valid in cycle t+3.
- SIGNED=1, 4×4, K=1, all a=−128, all w=127: every result is 0xFFFFC080 (−16256).
- First test repeated with 3 in_valid=0 cycles between beats: identical results. out_valid is still exactly ROWS+COLS−1 cycles after the last beat.
- DRAIN with out_ready=0 for 5 cycles:
  - out_row and out_idx = 0 hold stable, in_ready = 0.
  - After release, rows 0 and 1 appear on consecutive cycles, then busy falls.
- AW=16, DW=8, unsigned, K=2, all operands 255: results = 130050 mod 65536 = 64514.
- rst pulsed mid-FLUSH, then the first test is rerun:
  - During reset: out_valid = 0, busy = 0.
  - Rerun gives the exact first-test results, with no contamination from the aborted job.
